// File: rtl/spi_flash_responder.sv
// SPI NOR-flash target (mode 0, single-bit) answering READ, JEDEC ID and READ STATUS.
// SCK/CS_N/DI are oversampled on the local clock; READ data comes from a byte-wide sync memory.
`timescale 1ns/1ps
module spi_flash_responder #(
  parameter int          ADDR_W     = 16,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic              spi_clock_clk,
  input  logic              spi_clock_resetn,
  input  logic              io_flash_ck,
  input  logic              io_flash_cs_n,
  input  logic              io_flash_di,
  output logic              io_flash_do,
  output logic              io_flash_do_oe,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        last_cmd,
  output logic [3:0]        fsm_state
);

  // Shared command/address shifter; wide enough for an opcode and the used address bits.
  localparam int SH_W = (ADDR_W - 1 > 7) ? ADDR_W - 1 : 7;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CMD      = 4'd1,
    ADDR     = 4'd2,
    FETCH    = 4'd3,
    LOAD     = 4'd4,
    DATA_OUT = 4'd5,
    ID_OUT   = 4'd6,
    STAT_OUT = 4'd7,
    IGNORE   = 4'd8
  } state_t;

  state_t state, state_next;

  logic ck_s1, ck_s2, ck_prev;
  logic cs_s1, cs_s2;
  logic di_s1, di_s2;
  logic rise, fall, cs_high;

  logic [SH_W-1:0]   shift_in;
  logic [4:0]        bit_cnt;
  logic [7:0]        out_shift;
  logic [7:0]        pf_data;
  logic [7:0]        next_byte;
  logic [7:0]        cmd_byte;
  logic [ADDR_W-1:0] addr_word;
  logic [1:0]        byte_idx;
  logic              started;
  logic              rd_pending;
  logic              do_reg;

  // Chip select resets to "deselected" so nothing is decoded before the first real select.
  always_ff @(posedge spi_clock_clk or negedge spi_clock_resetn) begin
    if (!spi_clock_resetn) begin
      ck_s1   <= 1'b0;
      ck_s2   <= 1'b0;
      ck_prev <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      di_s1   <= 1'b0;
      di_s2   <= 1'b0;
    end else begin
      ck_s1   <= io_flash_ck;
      ck_s2   <= ck_s1;
      ck_prev <= ck_s2;
      cs_s1   <= io_flash_cs_n;
      cs_s2   <= cs_s1;
      di_s1   <= io_flash_di;
      di_s2   <= di_s1;
    end
  end

  assign rise      = ck_s2 & ~ck_prev;
  assign fall      = ~ck_s2 & ck_prev;
  assign cs_high   = cs_s2;
  assign cmd_byte  = {shift_in[6:0], di_s2};
  assign addr_word = {shift_in[ADDR_W-2:0], di_s2};

  always_ff @(posedge spi_clock_clk or negedge spi_clock_resetn) begin
    if (!spi_clock_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (cs_high) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = CMD;
        CMD: begin
          if (rise && bit_cnt == 5'd7) begin
            case (cmd_byte)
              8'h03:   state_next = ADDR;
              8'h9F:   state_next = ID_OUT;
              8'h05:   state_next = STAT_OUT;
              default: state_next = IGNORE;
            endcase
          end
        end
        ADDR:    if (rise && bit_cnt == 5'd23) state_next = FETCH;
        FETCH:   state_next = LOAD;
        LOAD:    state_next = DATA_OUT;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    fsm_state      = state;
    io_flash_do    = do_reg;
    io_flash_do_oe = 1'b0;
    next_byte      = 8'h00;
    case (state)
      DATA_OUT: begin
        io_flash_do_oe = ~cs_high;
        next_byte      = pf_data;
      end
      ID_OUT: begin
        io_flash_do_oe = ~cs_high;
        case (byte_idx)
          2'd1:    next_byte = JEDEC_ID[15:8];
          2'd2:    next_byte = JEDEC_ID[7:0];
          default: next_byte = 8'h00;
        endcase
      end
      STAT_OUT: begin
        io_flash_do_oe = ~cs_high;
        next_byte      = STATUS_VAL;
      end
      default: ;
    endcase
  end

  // Memory port: mem_rd_en is a one-cycle request with mem_addr valid in the same cycle;
  // mem_rd_data is valid exactly the following cycle and there is no back-pressure.
  always_ff @(posedge spi_clock_clk or negedge spi_clock_resetn) begin
    if (!spi_clock_resetn) begin
      shift_in   <= '0;
      bit_cnt    <= 5'd0;
      out_shift  <= 8'h00;
      pf_data    <= 8'h00;
      byte_idx   <= 2'd0;
      started    <= 1'b0;
      rd_pending <= 1'b0;
      do_reg     <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      last_cmd   <= 8'h00;
    end else begin
      mem_rd_en  <= 1'b0;
      rd_pending <= mem_rd_en;
      if (cs_high) begin
        bit_cnt    <= 5'd0;
        do_reg     <= 1'b0;
        started    <= 1'b0;
        rd_pending <= 1'b0;
      end else begin
        case (state)
          CMD: begin
            if (rise) begin
              shift_in <= {shift_in[SH_W-2:0], di_s2};
              if (bit_cnt == 5'd7) begin
                last_cmd <= cmd_byte;
                bit_cnt  <= 5'd0;
                started  <= 1'b0;
                if (cmd_byte == 8'h9F) begin
                  out_shift <= JEDEC_ID[23:16];
                  byte_idx  <= 2'd1;
                end else begin
                  out_shift <= STATUS_VAL;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ADDR: begin
            if (rise) begin
              shift_in <= {shift_in[SH_W-2:0], di_s2};
              if (bit_cnt == 5'd23) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= addr_word;
                bit_cnt   <= 5'd0;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          FETCH: begin
            mem_rd_en <= 1'b1;
            mem_addr  <= mem_addr + 1'b1;
          end
          LOAD: out_shift <= mem_rd_data;
          DATA_OUT, ID_OUT, STAT_OUT: begin
            if (state == DATA_OUT && rd_pending) pf_data <= mem_rd_data;
            if (fall) begin
              if (!started) begin
                do_reg  <= out_shift[7];
                started <= 1'b1;
                bit_cnt <= 5'd0;
              end else if (bit_cnt == 5'd7) begin
                // Byte boundary: swap in the next byte and refill the single-byte prefetch.
                out_shift <= next_byte;
                do_reg    <= next_byte[7];
                bit_cnt   <= 5'd0;
                if (state == ID_OUT && byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
                if (state == DATA_OUT) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= mem_addr + 1'b1;
                end
              end else begin
                out_shift <= {out_shift[6:0], 1'b0};
                do_reg    <= out_shift[6];
                bit_cnt   <= bit_cnt + 5'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: bit-banged SPI master, addr[7:0] memory model,
// byte and address scoreboards checked as MISO bytes and read strobes appear.
`timescale 1ns/1ps
module tb_spi_flash_responder;

  localparam int ADDR_W = 16;
  localparam int HALF   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ck;
  logic              cs_n;
  logic              di;
  logic              flash_do;
  logic              flash_oe;
  logic              rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data = 8'h00;
  logic [7:0]        last_cmd;
  logic [3:0]        fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_count = 0;
  int oe_cycles = 0;
  int spurious = 0;

  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  spi_flash_responder #(
    .ADDR_W    (ADDR_W),
    .JEDEC_ID  (24'hEF4016),
    .STATUS_VAL(8'h00)
  ) dut (
    .spi_clock_clk   (clk),
    .spi_clock_resetn(rst_n),
    .io_flash_ck     (ck),
    .io_flash_cs_n   (cs_n),
    .io_flash_di     (di),
    .io_flash_do     (flash_do),
    .io_flash_do_oe  (flash_oe),
    .mem_rd_en       (rd_en),
    .mem_addr        (mem_addr),
    .mem_rd_data     (mem_rd_data),
    .last_cmd        (last_cmd),
    .fsm_state       (fsm_state)
  );

  // memory model: data = low address byte, one cycle after the strobe
  always @(posedge clk) begin
    if (rd_en) mem_rd_data <= mem_addr[7:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard side for read strobes
  always @(negedge clk) begin
    if (flash_oe) oe_cycles++;
    if (rd_en) begin
      rd_count++;
      if (exp_addr_q.size() > 0) check("mem_addr", mem_addr, exp_addr_q.pop_front());
      else spurious++;
    end
  end

  // driver tasks
  task automatic xfer_bit(input logic d, output logic q);
    ck = 1'b0;
    di = d;
    repeat (HALF) @(negedge clk);
    q  = flash_do;
    ck = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic q;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], q);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic q;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b0, q);
      b = {b[6:0], q};
    end
  endtask

  task automatic recv_check(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      recv_byte(b);
      if (exp_q.size() > 0) check("rx_byte", b, exp_q.pop_front());
      else begin
        n_fail++;
        $display("FAIL rx_underflow: observed 0x%0h expected none", b);
      end
    end
  endtask

  task automatic begin_xfer();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_xfer();
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("oe_after_cs", flash_oe, 1'b0);
    repeat (3) @(negedge clk);
    ck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_read(input logic [23:0] a);
    send_byte(8'h03);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  initial begin
    int         snap;
    logic       q;
    logic [7:0] b;

    rst_n = 1'b0;
    ck    = 1'b0;
    cs_n  = 1'b1;
    di    = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_do", flash_do, 1'b0);
    check("rst_oe", flash_oe, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_last_cmd", last_cmd, 8'h00);
    check("rst_state", fsm_state, 4'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // JEDEC ID with trailing zero fill
    begin_xfer();
    send_byte(8'h9F);
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h16);
    exp_q.push_back(8'h00);
    recv_check(4);
    check("jedec_oe", flash_oe, 1'b1);
    check("jedec_last_cmd", last_cmd, 8'h9F);
    end_xfer();

    // READ at 0x000010, three bytes
    snap = rd_count;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(16'h0010 + 16'(i));
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h10 + 8'(i));
    begin_xfer();
    send_read(24'h000010);
    recv_check(3);
    end_xfer();
    check("read_rd_count", rd_count - snap, 4);
    check("read_addr_left", exp_addr_q.size(), 0);
    check("read_last_cmd", last_cmd, 8'h03);

    // READ across the 2^ADDR_W wrap
    exp_addr_q.push_back(16'hFFFE);
    exp_addr_q.push_back(16'hFFFF);
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0001);
    exp_addr_q.push_back(16'h0002);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    begin_xfer();
    send_read(24'h00FFFE);
    recv_check(4);
    end_xfer();
    check("wrap_addr_left", exp_addr_q.size(), 0);

    // abort after 5 address bits, then READ STATUS
    snap = rd_count;
    begin_xfer();
    send_byte(8'h03);
    for (int i = 0; i < 5; i++) xfer_bit(1'b0, q);
    end_xfer();
    check("abort_state", fsm_state, 4'd0);
    check("abort_no_rd", rd_count - snap, 0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    begin_xfer();
    send_byte(8'h05);
    recv_check(2);
    check("stat_oe", flash_oe, 1'b1);
    check("stat_last_cmd", last_cmd, 8'h05);
    end_xfer();

    // unknown opcode: output stays disabled
    begin_xfer();
    send_byte(8'hAB);
    snap = oe_cycles;
    recv_byte(b);
    recv_byte(b);
    check("ignore_oe_cycles", oe_cycles - snap, 0);
    check("ignore_last_cmd", last_cmd, 8'hAB);
    end_xfer();

    // asynchronous reset in the middle of DATA_OUT (byte 0xFF)
    exp_addr_q.push_back(16'h00FF);
    exp_addr_q.push_back(16'h0100);
    begin_xfer();
    send_read(24'h0000FF);
    for (int i = 0; i < 3; i++) begin
      xfer_bit(1'b0, q);
      check("pre_rst_bit", q, 1'b1);
    end
    check("pre_rst_oe", flash_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_do", flash_do, 1'b0);
    check("async_rst_oe", flash_oe, 1'b0);
    check("async_rst_rd_en", rd_en, 1'b0);
    check("async_rst_mem_addr", mem_addr, 16'h0000);
    check("async_rst_state", fsm_state, 4'd0);
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    ck   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_state", fsm_state, 4'd0);
    check("post_rst_last_cmd", last_cmd, 8'h00);
    check("rst_addr_left", exp_addr_q.size(), 0);

    // fresh JEDEC ID after reset
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h16);
    begin_xfer();
    send_byte(8'h9F);
    recv_check(3);
    check("post_rst_jedec_cmd", last_cmd, 8'h9F);
    end_xfer();

    check("spurious_rd", spurious, 0);
    check("exp_q_left", exp_q.size(), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI NOR-flash target (mode 0, single-bit) that answers the SoC's SPI flash master on the io_flash pins.
- Used for on-board loopback and simulation boot images in place of the physical flash.
- Oversamples SCK/CS_N/DI on its own clock and decodes READ (0x03), JEDEC ID (0x9F) and READ STATUS (0x05).
- Serves READ data from an external byte-wide synchronous ROM/RAM port.

Parameters:
- ADDR_W, 16, memory address width; the low ADDR_W bits of the 24-bit flash address are used and wrap at 2^ADDR_W.
- JEDEC_ID, 24'hEF4016, manufacturer/type/capacity bytes, MSB byte sent first.
- STATUS_VAL, 8'h00, constant status register value (never busy).

Ports:
- spi_clock_clk  in  1  system clock; must be ≥ 8× SCK frequency.
- spi_clock_resetn  in  1  asynchronous reset, active-low.
- io_flash_ck  in  1  SCK from master, asynchronous.
- io_flash_cs_n  in  1  chip select, active-low, asynchronous.
- io_flash_di  in  1  MOSI (master → flash), asynchronous.
- io_flash_do  out  1  MISO data.
- io_flash_do_oe  out  1  MISO output enable (tristate control at pad).
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rd_data  in  8  read data, valid exactly one clock after mem_rd_en.
- last_cmd  out  8  last fully received opcode (debug).

Behaviour:
- Synchronization:
  - ck, cs_n and di each pass through 2-flop synchronizers.
  - rise/fall = synced ck vs its previous value.
  - All decisions use synced signals.
- Reset: do=0, do_oe=0, mem_rd_en=0, mem_addr=0, last_cmd=0, state=IDLE, all counters and shifters cleared.
- cs_n high (synced), checked in every state with top priority:
  - state→IDLE; do_oe=0, do=0; bit counter=0; no mem_rd_en issued.
  - Deassertion mid-byte aborts silently.
- States:
  - IDLE: wait for synced cs_n=0 → CMD.
  - CMD: on each rise, shift di in MSB-first. On the 8th rise, last_cmd ← opcode, then:
    - 0x03 → ADDR
    - 0x9F → ID_OUT
    - 0x05 → STAT_OUT
    - otherwise → IGNORE
  - ADDR: 24 rises, MSB-first. On the 24th rise, mem_rd_en=1 for one clock with mem_addr = addr[ADDR_W-1:0]. The next clock loads mem_rd_data into the output shifter and issues a prefetch for addr+1 (mod 2^ADDR_W) → DATA_OUT.
  - DATA_OUT:
    - do_oe=1. Bit 7 of the shifter is presented on do by the first fall after entry.
    - Each subsequent fall shifts left; the 8th fall of a byte presents bit 7 of the prefetched byte, and the prefetch for the next address is issued.
    - Streams indefinitely; address wraps 2^ADDR_W-1 → 0.
  - ID_OUT: same bit timing. Sends JEDEC_ID[23:16], [15:8], [7:0], then 0x00 repeatedly.
  - STAT_OUT: sends STATUS_VAL repeatedly.
  - IGNORE: do_oe=0; ignore all edges until cs_n high.
- Edge timing:
  - Falls in CMD/ADDR are ignored; rises in output states are ignored (dummy MOSI).
  - do changes only within ≤3 clocks after a synced fall. With clk ≥ 8× SCK, do is stable ≥1 clock before the master's next rising edge.
- Output timing: the first output bit must be valid before the rise following the last command/address bit. The fetch completes ≤3 clocks after that rise, well within the half-period.
- Prefetch register: holds exactly one byte. No second request is issued until it has been consumed.
- SCK must be low when cs_n falls (mode 0). Behaviour with SCK high at select is undefined but must not lock up; the next cs_n high recovers.

Test Plan:
- JEDEC ID: cs_n low, send 0x9F, clock 32 more bits → MISO reads 0xEF, 0x40, 0x16, 0x00; last_cmd=0x9F; do_oe falls ≤3 clk after cs_n high.
- READ: memory model returns data = addr[7:0]; send 0x03 00 00 10, clock 24 bits → 0x10, 0x11, 0x12; mem_rd_en pulses once per byte plus one prefetch.
- Wrap (ADDR_W=16): READ at 0x00FFFE, clock 4 bytes → 0xFE, 0xFF, 0x00, 0x01; mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002.
- Abort: raise cs_n after 5 address bits → IDLE, no mem_rd_en. Next transaction, 0x05 + 16 clocks → 0x00, 0x00.
- Unknown opcode 0xAB then 16 clocks → do_oe stays 0 throughout; last_cmd=0xAB.
- Reset: assert spi_clock_resetn=0 mid-DATA_OUT → do, do_oe, mem_rd_en at 0 immediately (asynchronous). After release with cs_n high → IDLE; a fresh 0x9F read is correct.
